alu_op_issue: RTL and testbench

Issue stage on the producer side of the ALU operand interface. Accepts a 32-bit RV32 R/I-type instruction with its register-file read data, decodes it into `operand_a`, `operand_b` and the 5-bit `select_op` encoding the ALU consumes, and presents the result over a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` registered and sustains one instruction per cycle under backpressure.

---
 rtl/alu_op_issue_if.sv | 30 +++
 rtl/alu_op_issue.sv | 138 +++++++++++++
 tb/tb_alu_op_issue.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issue_if.sv
// ALU operand issue bus: instruction + register reads in, decoded ALU operands out.
// Ports: in_valid/in_ready/instr/rs1_data/rs2_data (upstream side),
//        out_valid/out_ready/operand_a/operand_b/select_op/rd_addr/reg_wr_en/illegal (ALU side).
interface alu_op_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [4:0]  select_op;
  logic [4:0]  rd_addr;
  logic        reg_wr_en;
  logic        illegal;

  // The issue stage itself: consumes instructions, produces decoded entries.
  modport slave (
    input  in_valid, instr, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, operand_a, operand_b, select_op, rd_addr, reg_wr_en, illegal
  );

  // The environment around the stage: upstream feeder plus ALU consumer.
  modport master (
    output in_valid, instr, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, operand_a, operand_b, select_op, rd_addr, reg_wr_en, illegal
  );
endinterface

// File: rtl/alu_op_issue.sv
// Purpose: decode RV32 add/sub/addi into ALU operands + select_op, issue via valid/ready.
// Latency: 1 cycle (accept at edge N -> out_valid after edge N when empty).
// Backpressure: 2-entry skid buffer, registered in_ready drops only when both entries are full.
// Ports: clk, rst (sync, active-high); bus = alu_op_issue_if.slave (input and output handshakes).
module alu_op_issue #(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_op_issue_if.slave bus
);

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  select_op;
    logic [4:0]  rd_addr;
    logic        reg_wr_en;
    logic        illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ADD     = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;
  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [4:0] SEL_ADD    = 5'b00000;
  localparam logic [4:0] SEL_SUB    = 5'b00001;

  // Slot 0 is the head driving the outputs; slot DEPTH-1 is the skid slot.
  entry_t buf_q [DEPTH];
  state_t state;
  logic   in_ready_q;
  logic   out_valid_q;
  entry_t dec;
  logic   accept;
  logic   issue;

  // Source-register index bits are resolved by the register file upstream.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^bus.instr[19:15];

  wire [6:0] opcode = bus.instr[6:0];
  wire [2:0] funct3 = bus.instr[14:12];
  wire [6:0] funct7 = bus.instr[31:25];

  // Default is the illegal/R-type shape: operands still carry rs1/rs2 so a
  // downstream trap handler sees consistent data.
  always_comb begin
    dec           = '0;
    dec.operand_a = bus.rs1_data;
    dec.operand_b = bus.rs2_data;
    dec.rd_addr   = bus.instr[11:7];
    dec.select_op = SEL_ADD;
    dec.reg_wr_en = 1'b0;
    dec.illegal   = 1'b1;
    if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_ADD) begin
      dec.reg_wr_en = 1'b1;
      dec.illegal   = 1'b0;
    end else if (opcode == OPC_OP && funct3 == F3_ADD && funct7 == F7_SUB) begin
      dec.select_op = SEL_SUB;
      dec.reg_wr_en = 1'b1;
      dec.illegal   = 1'b0;
    end else if (opcode == OPC_OP_IMM && funct3 == F3_ADD) begin
      dec.operand_b = {{20{bus.instr[31]}}, bus.instr[31:20]};
      dec.reg_wr_en = 1'b1;
      dec.illegal   = 1'b0;
    end
  end

  assign accept = bus.in_valid && in_ready_q;
  assign issue  = out_valid_q && bus.out_ready;

  // in_ready_q / out_valid_q are loaded with the values implied by the next
  // state, so both are pure flops and in_ready never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            buf_q[0]    <= dec;
            state       <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !issue) begin
            buf_q[DEPTH-1] <= dec;
            state          <= TWO;
            in_ready_q     <= 1'b0;
          end else if (accept && issue) begin
            // Head leaves and the newcomer takes its place in the same edge.
            buf_q[0] <= dec;
          end else if (issue) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so only an issue can happen.
          if (issue) begin
            buf_q[0]   <= buf_q[DEPTH-1];
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.operand_a = buf_q[0].operand_a;
  assign bus.operand_b = buf_q[0].operand_b;
  assign bus.select_op = buf_q[0].select_op;
  assign bus.rd_addr   = buf_q[0].rd_addr;
  assign bus.reg_wr_en = buf_q[0].reg_wr_en;
  assign bus.illegal   = buf_q[0].illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: directed decode cases, backpressure, random streaming, mid-run reset.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
// A queue-based reference model tracks the entries the stage should be holding.
module tb_alu_op_issue;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_accepted = 0;
  int   n_issued = 0;
  exp_t q[$];

  alu_op_issue_if bus();

  alu_op_issue #(.DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the instruction semantics.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic signed [11:0] imm;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    imm = ins[31:20];
    e.a = r1;
    e.b = r2;
    e.rd = ins[11:7];
    e.sel = 5'd0;
    e.we = 1'b0;
    e.ill = 1'b1;
    if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
      e.we = 1'b1; e.ill = 1'b0;
    end else if (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
      e.sel = 5'd1; e.we = 1'b1; e.ill = 1'b0;
    end else if (opc == 7'h13 && f3 == 3'd0) begin
      e.b = int'(imm); e.we = 1'b1; e.ill = 1'b0;
    end
    return e;
  endfunction

  function automatic exp_t obs();
    return {bus.operand_a, bus.operand_b, bus.select_op, bus.rd_addr, bus.reg_wr_en, bus.illegal};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 4);
    case (k)
      0: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
      1: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      2: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      3: ;
      default: w[6:0] = 7'h33;
    endcase
    return w;
  endfunction

  // Advance one clock and update the model from the handshakes the DUT saw.
  task automatic tick();
    logic acc;
    logic iss;
    exp_t e;
    acc = bus.in_valid && bus.in_ready && !rst;
    iss = bus.out_valid && bus.out_ready && !rst;
    e = model(bus.instr, bus.rs1_data, bus.rs2_data);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (iss && q.size() > 0) begin
        void'(q.pop_front());
        n_issued++;
      end
      if (acc) begin
        q.push_back(e);
        n_accepted++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = 32'h002081B3;
    bus.rs1_data = 32'h1234;
    bus.rs2_data = 32'h5678;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", obs()); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (obs() !== '0) begin errors++; $display("FAIL post_reset_data: got %h want 0", obs()); end
  endtask

  task automatic test_add();
    exp_t want;
    want = {32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0};
    bus.in_valid = 1'b1;
    bus.instr = 32'h002081B3;
    bus.rs1_data = 32'd5;
    bus.rs2_data = 32'd7;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", bus.out_valid); end
    checks++; if (obs() !== want) begin errors++; $display("FAIL add_data: got %h want %h", obs(), want); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    exp_t want_sub;
    exp_t want_addi;
    want_sub  = {32'd9, 32'd4, 5'd1, 5'd3, 1'b1, 1'b0};
    want_addi = {32'h10, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = 32'h402081B3;
    bus.rs1_data = 32'd9;
    bus.rs2_data = 32'd4;
    tick();
    bus.instr = 32'hFFF00293;
    bus.rs1_data = 32'h10;
    bus.rs2_data = 32'hABCD;
    checks++; if (obs() !== want_sub || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_sub: got %h v=%b want %h v=1", obs(), bus.out_valid, want_sub); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (obs() !== want_addi || bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_addi: got %h v=%b want %h v=1", obs(), bus.out_valid, want_addi); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    exp_t want;
    want = {32'h11, 32'h22, 5'd0, 5'd3, 1'b0, 1'b1};
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = 32'h0020C1B3;
    bus.rs1_data = 32'h11;
    bus.rs2_data = 32'h22;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid: got %b want 1", bus.out_valid); end
    checks++; if (obs() !== want) begin errors++; $display("FAIL illegal_data: got %h want %h", obs(), want); end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t want0;
    want0 = {32'h100, 32'h1, 5'd0, 5'd3, 1'b1, 1'b0};
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = 32'h002081B3; bus.rs1_data = 32'h100; bus.rs2_data = 32'h1;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_first: got rdy=%b v=%b want rdy=1 v=1", bus.in_ready, bus.out_valid); end
    bus.instr = 32'h402081B3; bus.rs1_data = 32'h200; bus.rs2_data = 32'h2;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_rdy: got %b want 0", bus.in_ready); end
    bus.instr = 32'hFFF00293; bus.rs1_data = 32'h300; bus.rs2_data = 32'h3;
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_rdy: got %b want 0", bus.in_ready); end
    checks++; if (obs() !== want0) begin errors++; $display("FAIL bp_head_stable: got %h want %h", obs(), want0); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy_rise: got %b want 1", bus.in_ready); end
    checks++; if (bus.operand_a !== 32'h200 || bus.select_op !== 5'd1) begin errors++; $display("FAIL bp_second: got a=%h sel=%h want a=200 sel=01", bus.operand_a, bus.select_op); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.operand_a !== 32'h300 || bus.operand_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL bp_third: got a=%h b=%h want a=300 b=ffffffff", bus.operand_a, bus.operand_b); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_stream();
    int acc0;
    int iss0;
    acc0 = n_accepted;
    iss0 = n_issued;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.instr = rand_instr();
      bus.rs1_data = 32'h5EED0000 + 32'(cyc);
      bus.rs2_data = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      checks++; if (bus.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL stream_valid cyc %0d: got %b want %b", cyc, bus.out_valid, q.size() != 0); end
      checks++; if (bus.in_ready !== (q.size() < 2)) begin errors++; $display("FAIL stream_ready cyc %0d: got %b want %b", cyc, bus.in_ready, q.size() < 2); end
      if (q.size() != 0) begin
        checks++; if (obs() !== q[0]) begin errors++; $display("FAIL stream_head cyc %0d: got %h want %h", cyc, obs(), q[0]); end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (q.size() != 0) begin
        checks++; if (obs() !== q[0]) begin errors++; $display("FAIL stream_drain_head: got %h want %h", obs(), q[0]); end
      end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: got %b want 0", bus.out_valid); end
    checks++; if ((n_issued - iss0) !== (n_accepted - acc0)) begin errors++; $display("FAIL stream_count: issued %0d want %0d", n_issued - iss0, n_accepted - acc0); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = 32'h002081B3; bus.rs1_data = 32'hDEAD0001; bus.rs2_data = 32'h1;
    tick();
    bus.rs1_data = 32'hDEAD0002;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b want 0", bus.in_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_cleared: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.rs1_data = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.operand_a !== 32'h55) begin errors++; $display("FAIL rmid_new: got v=%b a=%h want v=1 a=55", bus.out_valid, bus.operand_a); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost %0d: got v=%b a=%h want v=0", i, bus.out_valid, bus.operand_a); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.instr = '0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
